rasterizer_mem_arbiter: RTL and testbench
=========================================

# rasterizer_mem_arbiter

Two-port Avalon-MM arbiter that shares the rasterizer's single 26-bit memory master between the vertex fetch unit (port 0) and the pixel/framebuffer writer (port 1). It grants the bus round-robin with burst hold, so a requester's back-to-back transfers (e.g. a 15-word triangle fetch) stay contiguous. It tags every accepted read so in-order read data returns to the requester that issued it. It sits between the rasterizer units and the SDRAM/bridge master interface.

## Interface
- MAX_HOLD, 16: maximum accepted transfers per grant before the other requester may take the bus.
- TAG_LOG2, 4: log2 depth of the read-tag FIFO (max outstanding reads = 2**TAG_LOG2).
- clock  in  1  clock.
- reset  in  1  reset, asynchronous, active-low.
- sN_address  in  26  requester N address (N = 0, 1; same for all sN_ ports).
- sN_read, sN_write  in  1  requester N command.
- sN_byteenable  in  4  requester N byte enables.
- sN_writedata  in  32  requester N write data.
- sN_readdata  out  32  read data returned to requester N.
- sN_readdatavalid  out  1  read data valid for requester N.
- sN_waitrequest  out  1  stall to requester N.
- m_address  out  26  memory address.
- m_read, m_write  out  1  memory command.
- m_byteenable  out  4  memory byte enables.
- m_writedata  out  32  memory write data.
- m_readdata  in  32  memory read data.
- m_readdatavalid  in  1  memory read data valid; returns in issue order.
- m_waitrequest  in  1  memory stall.
- err_unexpected  out  1  sticky flag; set when readdatavalid arrives with no outstanding tag.

## Operation
- States: IDLE, GRANT0, GRANT1.
- reqN = sN_read | sN_write.
- last register: identifies the port served most recently; reset value 1, so port 0 wins first.
- IDLE:
  - No memory command is driven.
  - If exactly one reqN is high, go to GRANTN.
  - If both are high, grant the port not equal to last.
- GRANTN:
  - Mux sN_address, sN_read, sN_write, sN_byteenable and sN_writedata combinationally onto m_*.
  - sN_waitrequest = m_waitrequest | block.
  - Non-granted port: waitrequest = 1.
- block: high when sN_read is high and the tag FIFO is full. While block is high, m_read is forced to 0. m_write is unaffected.
- Accepted transfer: m_read | m_write, with m_waitrequest = 0, in a GRANT state.
- hold counter (5 bits):
  - Cleared when a grant is taken.
  - Incremented on each accepted transfer.
- Leaving GRANTN (evaluated at each clock edge):
  - If reqN = 0, go to GRANT(other) when the other port requests, else go to IDLE. Set last = N.
  - If an accepted transfer brings hold to MAX_HOLD and the other port requests, go to GRANT(other). Set last = N.
  - If that happens and the other port does not request, stay in GRANTN and clear hold.
- Tag FIFO:
  - On each accepted read, push the granted port ID.
  - On each m_readdatavalid, pop the head. Route m_readdata to sHEAD_readdata and pulse sHEAD_readdatavalid for that cycle.
  - The other port's readdatavalid is 0.
  - sN_readdata is always m_readdata; only valid is gated.
- Simultaneous push and pop: both happen and the count is unchanged.
- Full: a push is refused even if a pop occurs in the same cycle. block is evaluated on the registered count.
- Empty FIFO with m_readdatavalid: data is dropped, no sN_readdatavalid is asserted, and err_unexpected sets. err_unexpected clears only on reset.
- Grant switching does not wait for outstanding reads to drain; reads from both ports may be interleaved in the FIFO.

## Timing
- Reset values:
  - State IDLE, hold 0, FIFO empty, err_unexpected 0.
  - m_read = m_write = 0.
  - sN_readdatavalid = 0.
  - sN_waitrequest = 1.
- Arbitration latency: a request arriving while in IDLE sees its first command on m_* one cycle later.
- On a release/switch edge the new owner's command is on m_* in the next cycle; there is no idle gap.
- Read data path: m_readdatavalid to sN_readdatavalid is combinational, zero cycles.
- Reset asserted mid-operation:
  - Returns to IDLE immediately and clears the FIFO.
  - Reads returned later are flagged through err_unexpected.

## Test plan
- Port 0 only, 15 back-to-back reads at 0x100 stepping by 4, memory returns data after 3 cycles:
  - m_address goes 0x100..0x138 contiguously.
  - s0_readdatavalid pulses 15 times.
  - s1_readdatavalid stays 0.
- Both ports request in the same cycle after reset:
  - Port 0 is granted first.
  - When port 0 drops its request, port 1 is granted on the next cycle with no IDLE gap.
- MAX_HOLD=4, both ports hold requests continuously:
  - Grants alternate after every 4 accepted transfers: 0,0,0,0,1,1,1,1,...
- Interleaved reads with a 6-cycle memory latency, in order p0, p1, p0:
  - Returned words are routed 0, 1, 0 in that order.
- TAG_LOG2=2, 4 reads outstanding:
  - The fifth s0_read sees waitrequest = 1 and m_read = 0.
  - m_read is re-enabled the cycle after the first readdatavalid.
- Reset while 3 reads are outstanding, then 3 readdatavalid pulses:
  - No sN_readdatavalid is asserted.
  - err_unexpected = 1.

Source files
------------

// File: rtl/rasterizer_mem_arbiter.sv
// rtl/rasterizer_mem_arbiter.sv - two-port round-robin Avalon-MM arbiter with burst hold and read tagging
module rasterizer_mem_arbiter #(
  parameter int MAX_HOLD = 16,
  parameter int TAG_LOG2 = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [25:0] s0_address,
  input  logic        s0_read,
  input  logic        s0_write,
  input  logic [3:0]  s0_byteenable,
  input  logic [31:0] s0_writedata,
  output logic [31:0] s0_readdata,
  output logic        s0_readdatavalid,
  output logic        s0_waitrequest,
  input  logic [25:0] s1_address,
  input  logic        s1_read,
  input  logic        s1_write,
  input  logic [3:0]  s1_byteenable,
  input  logic [31:0] s1_writedata,
  output logic [31:0] s1_readdata,
  output logic        s1_readdatavalid,
  output logic        s1_waitrequest,
  output logic [25:0] m_address,
  output logic        m_read,
  output logic        m_write,
  output logic [3:0]  m_byteenable,
  output logic [31:0] m_writedata,
  input  logic [31:0] m_readdata,
  input  logic        m_readdatavalid,
  input  logic        m_waitrequest,
  output logic        err_unexpected
);
  localparam int DEPTH = 1 << TAG_LOG2;
  localparam logic [TAG_LOG2:0] FULL_COUNT = (TAG_LOG2 + 1)'(DEPTH);
  localparam logic [4:0] HOLD_LAST = 5'(MAX_HOLD - 1);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

  state_t state, state_next;
  logic last, last_next;
  logic [4:0] hold, hold_next;

  logic [DEPTH-1:0] tag_mem;
  logic [TAG_LOG2-1:0] wr_ptr, rd_ptr;
  logic [TAG_LOG2:0] count;
  logic err_q;

  logic req0, req1, granted, gport, own_req, other_req;
  logic sel_read, sel_write, fifo_full, fifo_empty, block;
  logic accept, push, pop, head;
  state_t other_grant;

  assign req0 = s0_read | s0_write;
  assign req1 = s1_read | s1_write;
  assign granted = (state != IDLE);
  assign gport = (state == GRANT1);
  assign own_req = gport ? req1 : req0;
  assign other_req = gport ? req0 : req1;
  assign other_grant = gport ? GRANT0 : GRANT1;

  assign sel_read = gport ? s1_read : s0_read;
  assign sel_write = gport ? s1_write : s0_write;
  assign fifo_full = (count == FULL_COUNT);
  assign fifo_empty = (count == '0);
  // A read with no free tag is held off; writes need no tag and pass.
  assign block = granted & sel_read & fifo_full;

  assign m_read = granted & sel_read & ~fifo_full;
  assign m_write = granted & sel_write;
  assign m_address = granted ? (gport ? s1_address : s0_address) : '0;
  assign m_byteenable = granted ? (gport ? s1_byteenable : s0_byteenable) : '0;
  assign m_writedata = granted ? (gport ? s1_writedata : s0_writedata) : '0;

  assign s0_waitrequest = (state == GRANT0) ? (m_waitrequest | block) : 1'b1;
  assign s1_waitrequest = (state == GRANT1) ? (m_waitrequest | block) : 1'b1;

  assign accept = (m_read | m_write) & ~m_waitrequest;
  assign push = accept & m_read;
  assign pop = m_readdatavalid & ~fifo_empty;
  assign head = tag_mem[rd_ptr];

  assign s0_readdata = m_readdata;
  assign s1_readdata = m_readdata;
  assign s0_readdatavalid = pop & ~head;
  assign s1_readdatavalid = pop & head;
  assign err_unexpected = err_q;

  always_comb begin
    state_next = state;
    last_next = last;
    hold_next = hold;
    case (state)
      IDLE: begin
        hold_next = '0;
        if (req0 && req1) state_next = last ? GRANT0 : GRANT1;
        else if (req0) state_next = GRANT0;
        else if (req1) state_next = GRANT1;
      end
      GRANT0, GRANT1: begin
        if (!own_req) begin
          state_next = other_req ? other_grant : IDLE;
          last_next = gport;
          hold_next = '0;
        end else if (accept && hold == HOLD_LAST) begin
          // Burst limit reached: yield only if someone is waiting.
          hold_next = '0;
          if (other_req) begin
            state_next = other_grant;
            last_next = gport;
          end
        end else if (accept) begin
          hold_next = hold + 5'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      last <= 1'b1;
      hold <= '0;
      tag_mem <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_next;
      last <= last_next;
      hold <= hold_next;
      if (push) begin
        tag_mem[wr_ptr] <= gport;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10: count <= count + 1'b1;
        2'b01: count <= count - 1'b1;
        default: count <= count;
      endcase
      if (m_readdatavalid && fifo_empty) err_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_rasterizer_mem_arbiter.sv
// tb/tb_rasterizer_mem_arbiter.sv - randomized self-checking bench for rasterizer_mem_arbiter
`timescale 1ns/1ps
module tb_rasterizer_mem_arbiter;
  localparam int MAX_HOLD = 4;
  localparam int TAG_LOG2 = 2;

  typedef struct packed {
    logic [25:0] a;
    logic        w;
    logic [3:0]  be;
    logic [31:0] wd;
  } cmd_t;

  typedef struct packed {
    logic [31:0] d;
    int          due;
  } pend_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic [25:0] s_address [2];
  logic [1:0] s_read = 2'b00;
  logic [1:0] s_write = 2'b00;
  logic [3:0] s_byteenable [2];
  logic [31:0] s_writedata [2];
  wire [31:0] s0_readdata, s1_readdata;
  wire [1:0] s_readdatavalid, s_waitrequest;
  wire [25:0] m_address;
  wire m_read, m_write;
  wire [3:0] m_byteenable;
  wire [31:0] m_writedata;
  logic [31:0] m_readdata = 32'h0;
  logic m_readdatavalid = 1'b0;
  logic m_waitrequest = 1'b0;
  wire err_unexpected;

  int errors = 0;
  int checks = 0;
  int tmo_err = 0;
  int mrdv_count = 0;
  int cyc = 0;
  int mem_lat = 3;
  bit mem_wait_rand = 1'b0;

  cmd_t mem_log[$];
  cmd_t iss0[$], iss1[$];
  logic [31:0] exp0[$], exp1[$], ret0[$], ret1[$];
  int ret_order[$];
  pend_t pend[$];

  rasterizer_mem_arbiter #(.MAX_HOLD(MAX_HOLD), .TAG_LOG2(TAG_LOG2)) dut (
    .clock(clock), .reset(reset),
    .s0_address(s_address[0]), .s0_read(s_read[0]), .s0_write(s_write[0]),
    .s0_byteenable(s_byteenable[0]), .s0_writedata(s_writedata[0]),
    .s0_readdata(s0_readdata), .s0_readdatavalid(s_readdatavalid[0]), .s0_waitrequest(s_waitrequest[0]),
    .s1_address(s_address[1]), .s1_read(s_read[1]), .s1_write(s_write[1]),
    .s1_byteenable(s_byteenable[1]), .s1_writedata(s_writedata[1]),
    .s1_readdata(s1_readdata), .s1_readdatavalid(s_readdatavalid[1]), .s1_waitrequest(s_waitrequest[1]),
    .m_address(m_address), .m_read(m_read), .m_write(m_write),
    .m_byteenable(m_byteenable), .m_writedata(m_writedata),
    .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid), .m_waitrequest(m_waitrequest),
    .err_unexpected(err_unexpected)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] fdata(input logic [25:0] a);
    return {a, 6'h15} ^ 32'h5A3C96E1;
  endfunction

  // Memory slave model: in-order returns after mem_lat cycles, optional random stalls.
  initial begin
    logic acc_rd;
    logic [25:0] rd_addr;
    cmd_t c;
    pend_t pe;
    forever begin
      @(negedge clock);
      acc_rd = m_read & ~m_waitrequest;
      rd_addr = m_address;
      if ((m_read || m_write) && !m_waitrequest) begin
        c.a = m_address; c.w = m_write; c.be = m_byteenable;
        c.wd = m_write ? m_writedata : 32'h0;
        mem_log.push_back(c);
      end
      if (s_readdatavalid[0]) begin ret0.push_back(s0_readdata); ret_order.push_back(0); end
      if (s_readdatavalid[1]) begin ret1.push_back(s1_readdata); ret_order.push_back(1); end
      if (m_readdatavalid) mrdv_count++;
      @(posedge clock);
      #1;
      cyc++;
      if (acc_rd) begin
        pe.d = fdata(rd_addr);
        pe.due = cyc + mem_lat - 1;
        pend.push_back(pe);
      end
      m_readdatavalid = 1'b0;
      m_readdata = $urandom;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        m_readdata = pend[0].d;
        m_readdatavalid = 1'b1;
        void'(pend.pop_front());
      end
      m_waitrequest = mem_wait_rand ? ($urandom_range(0, 3) == 0) : 1'b0;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, want finish before 3ms");
    $fatal(1, "watchdog");
  end

  task automatic clear_scoreboard();
    mem_log.delete(); iss0.delete(); iss1.delete();
    exp0.delete(); exp1.delete(); ret0.delete(); ret1.delete();
    ret_order.delete();
    mrdv_count = 0;
    tmo_err = 0;
  endtask

  task automatic wait_drain();
    int quiet;
    quiet = 0;
    for (int k = 0; k < 2000 && quiet < 4; k++) begin
      @(negedge clock);
      if (pend.size() == 0 && !m_readdatavalid) quiet++;
      else quiet = 0;
    end
    if (quiet < 4) tmo_err++;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    s_read = 2'b00;
    s_write = 2'b00;
    wait_drain();
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    clear_scoreboard();
  endtask

  // Avalon master: holds each command until accepted, optional random idle gaps.
  task automatic requester(input int p, input int n, input logic [25:0] base,
                           input int stride, input int mode, input int gap_max);
    cmd_t c;
    int tmo, gap;
    bit done;
    for (int i = 0; i < n; i++) begin
      c.a = base + 26'(i * stride);
      c.w = (mode == 2) ? 1'($urandom_range(0, 1)) : (mode == 1);
      c.be = 4'($urandom);
      c.wd = c.w ? 32'($urandom) : 32'h0;
      s_address[p] = c.a;
      s_byteenable[p] = c.be;
      s_writedata[p] = c.w ? c.wd : 32'($urandom);
      s_read[p] = ~c.w;
      s_write[p] = c.w;
      tmo = 0;
      done = 1'b0;
      while (!done) begin
        @(negedge clock);
        done = !s_waitrequest[p];
        @(posedge clock);
        #1;
        if (!done) begin
          tmo++;
          if (tmo > 1000) begin tmo_err++; done = 1'b1; end
        end
      end
      if (p == 0) iss0.push_back(c); else iss1.push_back(c);
      if (!c.w) begin
        if (p == 0) exp0.push_back(fdata(c.a)); else exp1.push_back(fdata(c.a));
      end
      gap = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
      if (gap > 0) begin
        s_read[p] = 1'b0;
        s_write[p] = 1'b0;
        repeat (gap) @(posedge clock);
        #1;
      end
    end
    s_read[p] = 1'b0;
    s_write[p] = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    s_read = 2'b11;
    @(negedge clock);
    checks++;
    if (m_read !== 1'b0 || m_write !== 1'b0) begin
      errors++; $display("FAIL reset_m_cmd: got read=%b write=%b, want 0 0", m_read, m_write);
    end
    checks++;
    if (s_waitrequest !== 2'b11) begin
      errors++; $display("FAIL reset_waitrequest: got %b, want 11", s_waitrequest);
    end
    checks++;
    if (s_readdatavalid !== 2'b00) begin
      errors++; $display("FAIL reset_rdv: got %b, want 00", s_readdatavalid);
    end
    checks++;
    if (err_unexpected !== 1'b0) begin
      errors++; $display("FAIL reset_err: got %b, want 0", err_unexpected);
    end
    s_read = 2'b00;
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    clear_scoreboard();
  endtask

  task automatic test_burst_single();
    int bad;
    do_reset();
    mem_lat = 3;
    mem_wait_rand = 1'b0;
    requester(0, 15, 26'h100, 4, 0, 0);
    wait_drain();
    checks++;
    if (tmo_err != 0) begin errors++; $display("FAIL burst_timeout: got %0d, want 0", tmo_err); end
    checks++;
    if (mem_log.size() != 15) begin
      errors++; $display("FAIL burst_count: got %0d, want 15", mem_log.size());
    end else begin
      bad = 0;
      for (int i = 0; i < 15; i++)
        if (mem_log[i].a !== 26'h100 + 26'(4 * i) || mem_log[i].w !== 1'b0) bad++;
      checks++;
      if (bad != 0) begin errors++; $display("FAIL burst_addr_seq: got %0d wrong, want 0", bad); end
    end
    checks++;
    if (ret0.size() != 15) begin
      errors++; $display("FAIL burst_s0_rdv: got %0d pulses, want 15", ret0.size());
    end else begin
      bad = 0;
      for (int i = 0; i < 15; i++) if (ret0[i] !== fdata(26'h100 + 26'(4 * i))) bad++;
      checks++;
      if (bad != 0) begin errors++; $display("FAIL burst_data: got %0d wrong, want 0", bad); end
    end
    checks++;
    if (ret1.size() != 0) begin errors++; $display("FAIL burst_s1_rdv: got %0d, want 0", ret1.size()); end
  endtask

  task automatic test_both_same_cycle();
    do_reset();
    mem_lat = 3;
    mem_wait_rand = 1'b0;
    s_address[0] = 26'h0000040; s_address[1] = 26'h1000040;
    s_byteenable[0] = 4'hF; s_byteenable[1] = 4'hF;
    s_writedata[0] = 32'h11112222; s_writedata[1] = 32'h33334444;
    s_write = 2'b11;
    @(negedge clock);
    checks++;
    if (m_write !== 1'b0 || s_waitrequest !== 2'b11) begin
      errors++; $display("FAIL both_idle_cycle: got m_write=%b wait=%b, want 0 11", m_write, s_waitrequest);
    end
    @(posedge clock); #1;
    @(negedge clock);
    checks++;
    if (m_write !== 1'b1 || m_address !== 26'h0000040 || s_waitrequest !== 2'b10) begin
      errors++; $display("FAIL both_first_p0: got m_write=%b addr=%h wait=%b, want 1 0000040 10",
                         m_write, m_address, s_waitrequest);
    end
    @(posedge clock); #1;
    s_write[0] = 1'b0;
    @(negedge clock);
    checks++;
    if (m_write !== 1'b0 || s_waitrequest[1] !== 1'b1) begin
      errors++; $display("FAIL both_release: got m_write=%b s1_wait=%b, want 0 1", m_write, s_waitrequest[1]);
    end
    @(posedge clock); #1;
    @(negedge clock);
    checks++;
    if (m_write !== 1'b1 || m_address !== 26'h1000040 || m_writedata !== 32'h33334444 || s_waitrequest !== 2'b01) begin
      errors++; $display("FAIL both_switch_p1: got m_write=%b addr=%h data=%h wait=%b, want 1 1000040 33334444 01",
                         m_write, m_address, m_writedata, s_waitrequest);
    end
    @(posedge clock); #1;
    s_write[1] = 1'b0;
    wait_drain();
    checks++;
    if (mem_log.size() != 2) begin errors++; $display("FAIL both_count: got %0d, want 2", mem_log.size()); end
  endtask

  task automatic test_max_hold();
    int rem[2];
    int cur, take, bad, i0, i1;
    int exp_port[$];
    do_reset();
    mem_lat = 2;
    mem_wait_rand = 1'b1;
    fork
      requester(0, 12, 26'h0001000, 4, 1, 0);
      requester(1, 12, 26'h1002000, 4, 1, 0);
    join
    wait_drain();
    rem[0] = 12; rem[1] = 12; cur = 0;
    while (rem[0] + rem[1] > 0) begin
      take = (rem[cur] < MAX_HOLD) ? rem[cur] : MAX_HOLD;
      repeat (take) exp_port.push_back(cur);
      rem[cur] -= take;
      if (rem[1 - cur] > 0) cur = 1 - cur;
    end
    checks++;
    if (tmo_err != 0) begin errors++; $display("FAIL hold_timeout: got %0d, want 0", tmo_err); end
    checks++;
    if (mem_log.size() != exp_port.size()) begin
      errors++; $display("FAIL hold_count: got %0d, want %0d", mem_log.size(), exp_port.size());
    end else begin
      bad = 0;
      foreach (mem_log[i]) if (int'(mem_log[i].a[24]) != exp_port[i]) bad++;
      checks++;
      if (bad != 0) begin errors++; $display("FAIL hold_grant_seq: got %0d out of place, want 0", bad); end
    end
    bad = 0; i0 = 0; i1 = 0;
    foreach (mem_log[i]) begin
      if (mem_log[i].a[24]) begin
        if (i1 >= iss1.size() || mem_log[i] !== iss1[i1]) bad++;
        i1++;
      end else begin
        if (i0 >= iss0.size() || mem_log[i] !== iss0[i0]) bad++;
        i0++;
      end
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL hold_cmd_content: got %0d wrong, want 0", bad); end
  endtask

  task automatic test_interleave();
    do_reset();
    mem_lat = 6;
    mem_wait_rand = 1'b0;
    requester(0, 1, 26'h0000300, 0, 0, 0);
    requester(1, 1, 26'h1000300, 0, 0, 0);
    requester(0, 1, 26'h0000304, 0, 0, 0);
    wait_drain();
    checks++;
    if (ret_order.size() != 3) begin
      errors++; $display("FAIL inter_count: got %0d, want 3", ret_order.size());
    end else begin
      checks++;
      if (ret_order[0] != 0 || ret_order[1] != 1 || ret_order[2] != 0) begin
        errors++; $display("FAIL inter_route: got %0d %0d %0d, want 0 1 0", ret_order[0], ret_order[1], ret_order[2]);
      end
    end
    checks++;
    if (ret0.size() != 2 || ret1.size() != 1) begin
      errors++; $display("FAIL inter_split: got %0d/%0d, want 2/1", ret0.size(), ret1.size());
    end else if (ret0[0] !== fdata(26'h0000300) || ret1[0] !== fdata(26'h1000300) || ret0[1] !== fdata(26'h0000304)) begin
      errors++; $display("FAIL inter_data: got %h %h %h, want %h %h %h", ret0[0], ret1[0], ret0[1],
                         fdata(26'h0000300), fdata(26'h1000300), fdata(26'h0000304));
    end
  endtask

  task automatic test_full_block();
    int accepted, leaked;
    bit seen;
    do_reset();
    mem_lat = 20;
    mem_wait_rand = 1'b0;
    s_address[0] = 26'h0000400;
    s_byteenable[0] = 4'hF;
    s_read[0] = 1'b1;
    accepted = 0;
    for (int k = 0; k < 20 && accepted < 4; k++) begin
      @(negedge clock);
      if (!s_waitrequest[0]) begin accepted++; exp0.push_back(fdata(26'h0000400)); end
      @(posedge clock); #1;
    end
    checks++;
    if (accepted != 4) begin errors++; $display("FAIL full_accepts: got %0d, want 4", accepted); end
    @(negedge clock);
    checks++;
    if (s_waitrequest[0] !== 1'b1 || m_read !== 1'b0) begin
      errors++; $display("FAIL full_block: got wait=%b m_read=%b, want 1 0", s_waitrequest[0], m_read);
    end
    seen = 1'b0;
    leaked = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clock);
      if (m_read) leaked++;
      seen = m_readdatavalid;
      @(posedge clock); #1;
    end
    checks++;
    if (!seen || leaked != 0) begin
      errors++; $display("FAIL full_hold: got rdv_seen=%b reads_leaked=%0d, want 1 0", seen, leaked);
    end
    @(negedge clock);
    checks++;
    if (m_read !== 1'b1 || s_waitrequest[0] !== 1'b0) begin
      errors++; $display("FAIL full_reenable: got m_read=%b wait=%b, want 1 0", m_read, s_waitrequest[0]);
    end else exp0.push_back(fdata(26'h0000400));
    @(posedge clock); #1;
    s_read[0] = 1'b0;
    wait_drain();
    checks++;
    if (ret0.size() != exp0.size() || ret0.size() != 5) begin
      errors++; $display("FAIL full_returns: got %0d, want 5", ret0.size());
    end
  endtask

  task automatic test_reset_outstanding();
    do_reset();
    mem_lat = 10;
    mem_wait_rand = 1'b0;
    requester(0, 3, 26'h0000500, 4, 0, 0);
    reset = 1'b0;
    @(posedge clock); #1;
    clear_scoreboard();
    @(posedge clock); #1;
    reset = 1'b1;
    wait_drain();
    checks++;
    if (ret0.size() + ret1.size() != 0) begin
      errors++; $display("FAIL rst_out_rdv: got %0d pulses, want 0", ret0.size() + ret1.size());
    end
    checks++;
    if (mrdv_count != 3) begin errors++; $display("FAIL rst_out_mem_returns: got %0d, want 3", mrdv_count); end
    checks++;
    if (err_unexpected !== 1'b1) begin errors++; $display("FAIL rst_out_err: got %b, want 1", err_unexpected); end
    do_reset();
    checks++;
    if (err_unexpected !== 1'b0) begin errors++; $display("FAIL rst_err_clear: got %b, want 0", err_unexpected); end
  endtask

  task automatic test_random();
    int n0, n1, bad, i0, i1;
    logic [25:0] b0;
    for (int r = 0; r < 3; r++) begin
      do_reset();
      mem_lat = $urandom_range(1, 8);
      mem_wait_rand = 1'b1;
      n0 = $urandom_range(8, 20);
      n1 = $urandom_range(8, 20);
      b0 = 26'($urandom_range(0, 32'h3FFFF)) << 2;
      fork
        requester(0, n0, b0, 4, 2, 3);
        requester(1, n1, 26'h1000000 | b0, 4, 2, 3);
      join
      wait_drain();
      checks++;
      if (tmo_err != 0) begin errors++; $display("FAIL rand%0d_timeout: got %0d, want 0", r, tmo_err); end
      bad = 0; i0 = 0; i1 = 0;
      foreach (mem_log[i]) begin
        if (mem_log[i].a[24]) begin
          if (i1 >= iss1.size() || mem_log[i] !== iss1[i1]) bad++;
          i1++;
        end else begin
          if (i0 >= iss0.size() || mem_log[i] !== iss0[i0]) bad++;
          i0++;
        end
      end
      checks++;
      if (bad != 0 || i0 != n0 || i1 != n1) begin
        errors++; $display("FAIL rand%0d_cmds: got %0d wrong, %0d/%0d cmds, want 0, %0d/%0d", r, bad, i0, i1, n0, n1);
      end
      bad = 0;
      if (ret0.size() != exp0.size() || ret1.size() != exp1.size()) bad++;
      else begin
        foreach (ret0[i]) if (ret0[i] !== exp0[i]) bad++;
        foreach (ret1[i]) if (ret1[i] !== exp1[i]) bad++;
      end
      checks++;
      if (bad != 0) begin
        errors++; $display("FAIL rand%0d_readdata: got %0d/%0d words (%0d bad), want %0d/%0d", r,
                           ret0.size(), ret1.size(), bad, exp0.size(), exp1.size());
      end
      checks++;
      if (err_unexpected !== 1'b0) begin errors++; $display("FAIL rand%0d_err: got %b, want 0", r, err_unexpected); end
    end
  endtask

  initial begin
    s_address[0] = '0; s_address[1] = '0;
    s_byteenable[0] = '0; s_byteenable[1] = '0;
    s_writedata[0] = '0; s_writedata[1] = '0;
    test_reset();
    test_burst_single();
    test_both_same_cycle();
    test_max_hold();
    test_interleave();
    test_full_block();
    test_reset_outstanding();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
